chiplib_pri_queue_pop_prefetch: RTL and testbench

Pop-side controller for the priority queue, sitting between the queue core's combinational head/pop interface and a downstream valid/ready consumer.
It generalises the single-entry pop skid buffer to a parametrised Depth-entry prefetch FIFO with a same-cycle bypass, so the queue can keep draining while the consumer stalls.
It adds a synchronous flush and an occupancy output.
Entries moved into the prefetch FIFO are committed: later higher-priority pushes do not overtake them. Depth therefore trades ordering freshness for stall tolerance.

---
 rtl/chiplib_pri_queue_pop_prefetch.sv | 122 ++++++++++++
 tb/tb_chiplib_pri_queue_pop_prefetch.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chiplib_pri_queue_pop_prefetch.sv
// Pop-side controller for the priority queue.
// Pulls entries from the queue core's combinational head/pop interface into a
// Depth-entry prefetch FIFO. When the FIFO is empty, the queue head is passed
// straight through to the consumer in the same cycle (bypass).
// Entries in the FIFO are committed: a later higher-priority push into the core
// cannot overtake them.
//
// Handshake: a consumer transfer happens on a rising clk edge when
// pop_valid && pop_ready. Once pop_valid is high, pop_data/pop_pri/pop_valid
// hold until that transfer happens. The only exceptions are flush and rst,
// which withdraw the offer. queue_pop_valid is a strobe that removes the queue
// head at the same edge. It is never asserted while the core reports empty.
module chiplib_pri_queue_pop_prefetch #(
  parameter int DataWidth     = 64,
  parameter int PriorityWidth = 16,
  parameter int Depth         = 2,
  parameter int CountWidth    = $clog2(Depth + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  output logic [DataWidth-1:0]     pop_data,
  output logic [PriorityWidth-1:0] pop_pri,
  output logic                     pop_valid,
  input  logic                     pop_ready,
  output logic                     queue_pop_valid,
  input  logic [DataWidth-1:0]     queue_pop_data,
  input  logic [PriorityWidth-1:0] queue_pop_pri,
  input  logic                     empty,
  output logic [CountWidth-1:0]    count
);

  if (Depth < 1) begin : g_depth_check
    $error("chiplib_pri_queue_pop_prefetch: Depth must be 1 or more");
  end

  // Pointers wrap at Depth explicitly, so Depth need not be a power of two.
  // Storage is rounded up to the pointer range so every pointer value indexes
  // a real slot. Slots at Depth and above are never addressed.
  localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int MemDepth = 2 ** PtrWidth;
  localparam logic [PtrWidth-1:0]   LastPtr   = PtrWidth'(Depth - 1);
  localparam logic [CountWidth-1:0] FullCount = CountWidth'(Depth);

  logic [DataWidth-1:0]     r_data_mem [MemDepth];
  logic [PriorityWidth-1:0] r_pri_mem  [MemDepth];
  logic [PtrWidth-1:0]      r_rd_ptr;
  logic [PtrWidth-1:0]      r_wr_ptr;
  logic [CountWidth-1:0]    r_count;

  logic                w_has_data;
  logic                w_full;
  logic                w_fire;
  logic                w_rd;
  logic                w_byp;
  logic                w_wr;
  logic [PtrWidth-1:0] w_rd_ptr_nxt;
  logic [PtrWidth-1:0] w_wr_ptr_nxt;

  // Consumer-facing mux, handshake qualifiers and the queue pop strobe.
  // rst and flush both withdraw the offer and block any queue pop, so nothing
  // is taken from the core in a cycle whose FIFO contents are being discarded.
  always_comb begin
    w_has_data      = (r_count != '0);
    w_full          = (r_count == FullCount);
    pop_valid       = 1'b0;
    pop_data        = queue_pop_data;
    pop_pri         = queue_pop_pri;
    queue_pop_valid = 1'b0;
    w_wr_ptr_nxt    = (r_wr_ptr == LastPtr) ? '0 : r_wr_ptr + 1'b1;
    w_rd_ptr_nxt    = (r_rd_ptr == LastPtr) ? '0 : r_rd_ptr + 1'b1;

    if (w_has_data) begin
      pop_data = r_data_mem[r_rd_ptr];
      pop_pri  = r_pri_mem[r_rd_ptr];
    end

    if (!rst && !flush) begin
      pop_valid = w_has_data | ~empty;
    end

    w_fire = pop_valid & pop_ready;
    w_rd   = w_fire & w_has_data;
    // With the FIFO empty and the consumer ready, the head goes straight out.
    w_byp  = ~w_has_data & pop_ready;

    if (!rst && !flush) begin
      queue_pop_valid = ~empty & (~w_full | w_rd);
    end

    w_wr = queue_pop_valid & ~w_byp;
  end

  // Occupancy and pointer state. Flush clears the FIFO exactly like reset.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= w_wr_ptr_nxt;
      end
      if (w_rd) begin
        r_rd_ptr <= w_rd_ptr_nxt;
      end
      r_count <= r_count + CountWidth'(w_wr) - CountWidth'(w_rd);
    end
  end

  // FIFO storage. The write is written at the tail. It is not reset because
  // the contents are only read while count is nonzero.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_data_mem[r_wr_ptr] <= queue_pop_data;
      r_pri_mem[r_wr_ptr]  <= queue_pop_pri;
    end
  end

  assign count = r_count;

endmodule

// File: tb/tb_chiplib_pri_queue_pop_prefetch.sv
// Bench for chiplib_pri_queue_pop_prefetch. It builds four instances with
// Depth 2, 4, 1 and 3. All four share the same inputs. sel chooses the instance
// whose outputs drive the model and are compared.
// The queue core is modelled as a priority-sorted list. The consumer's
// expectations come from a queue of entries popped from the core but not yet
// delivered.
module tb_chiplib_pri_queue_pop_prefetch;

  localparam int DW = 16;
  localparam int PW = 8;
  localparam int W  = DW + PW;
  localparam int NI = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          pop_ready = 1'b0;
  logic          empty = 1'b1;
  logic [DW-1:0] queue_pop_data = '0;
  logic [PW-1:0] queue_pop_pri = '0;

  logic [DW-1:0] pop_data_v  [NI];
  logic [PW-1:0] pop_pri_v   [NI];
  logic          pop_valid_v [NI];
  logic          qpv_v       [NI];
  logic [2:0]    count_v     [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int D  = (g == 0) ? 2 : (g == 1) ? 4 : (g == 2) ? 1 : 3;
    localparam int CW = $clog2(D + 1);
    logic [CW-1:0] w_cnt;
    chiplib_pri_queue_pop_prefetch #(
      .DataWidth(DW), .PriorityWidth(PW), .Depth(D)
    ) u_dut (
      .clk(clk), .rst(rst), .flush(flush),
      .pop_data(pop_data_v[g]), .pop_pri(pop_pri_v[g]),
      .pop_valid(pop_valid_v[g]), .pop_ready(pop_ready),
      .queue_pop_valid(qpv_v[g]), .queue_pop_data(queue_pop_data),
      .queue_pop_pri(queue_pop_pri), .empty(empty), .count(w_cnt)
    );
    assign count_v[g] = 3'(w_cnt);
  end

  // reference model state
  logic [W-1:0] core_q[$];
  logic [W-1:0] exp_q[$];
  int           sel = 0;
  int           dep = 2;
  int           n_vec = 0;
  int           n_err = 0;
  int           cyc = 0;
  bit           e_pv, e_fire, e_qpv;
  logic [W-1:0] e_head;
  bit           hold_valid = 1'b0;
  logic [W-1:0] hold_val;

  function automatic int depth_of(input int s);
    case (s)
      0: return 2;
      1: return 4;
      2: return 1;
      default: return 3;
    endcase
  endfunction

  // The queue core keeps its entries sorted by priority, highest first.
  // Entries with equal priority stay in arrival order.
  task automatic push_core(input logic [PW-1:0] pri, input logic [DW-1:0] data);
    int i;
    i = 0;
    while (i < core_q.size() && core_q[i][W-1:DW] >= pri) i++;
    core_q.insert(i, {pri, data});
  endtask

  task automatic push_random();
    push_core(PW'($urandom_range(0, 255)), DW'($urandom));
  endtask

  task automatic drive_core();
    empty = (core_q.size() == 0);
    if (core_q.size() != 0) {queue_pop_pri, queue_pop_data} = core_q[0];
    else {queue_pop_pri, queue_pop_data} = W'($urandom);
  endtask

  // Model step, first half. Present the core head, then at the falling edge
  // compare the combinational outputs with the model's view.
  task automatic eval();
    int sz;
    bit ce;
    drive_core();
    @(negedge clk);
    sz     = exp_q.size();
    ce     = (core_q.size() == 0);
    e_pv   = !flush && !rst && (sz > 0 || !ce);
    e_head = (sz > 0) ? exp_q[0] : (ce ? '0 : core_q[0]);
    e_fire = e_pv && pop_ready;
    e_qpv  = !ce && !flush && !rst && (sz < dep || (e_fire && sz > 0));
    if (!rst) begin
      n_vec++;
      if (pop_valid_v[sel] !== e_pv) begin
        n_err++;
        $display("FAIL pop_valid: cycle %0d got %0b expected %0b", cyc, pop_valid_v[sel], e_pv);
      end
    end
    if (e_pv) begin
      n_vec++;
      if ({pop_pri_v[sel], pop_data_v[sel]} !== e_head) begin
        n_err++;
        $display("FAIL pop_entry: cycle %0d got %h expected %h", cyc, {pop_pri_v[sel], pop_data_v[sel]}, e_head);
      end
    end
    n_vec++;
    if (qpv_v[sel] !== e_qpv) begin
      n_err++;
      $display("FAIL queue_pop_valid: cycle %0d got %0b expected %0b", cyc, qpv_v[sel], e_qpv);
    end
    if (hold_valid && !flush && !rst) begin
      n_vec++;
      if (pop_valid_v[sel] !== 1'b1 || {pop_pri_v[sel], pop_data_v[sel]} !== hold_val) begin
        n_err++;
        $display("FAIL stall_stable: cycle %0d got %0b/%h expected 1/%h", cyc, pop_valid_v[sel], {pop_pri_v[sel], pop_data_v[sel]}, hold_val);
      end
    end
    hold_valid = e_pv && !pop_ready && !flush && !rst;
    hold_val   = e_head;
  endtask

  // Model step, second half. Take the clock edge, update the model, then check
  // the occupancy.
  task automatic advance();
    logic [W-1:0] tmp;
    @(posedge clk);
    #1;
    cyc++;
    if (rst || flush) begin
      exp_q.delete();
    end else begin
      if (e_qpv) begin
        tmp = core_q.pop_front();
        exp_q.push_back(tmp);
      end
      if (e_fire) tmp = exp_q.pop_front();
    end
    n_vec++;
    if (count_v[sel] !== 3'(exp_q.size())) begin
      n_err++;
      $display("FAIL count: cycle %0d got %0d expected %0d", cyc, count_v[sel], exp_q.size());
    end
    n_vec++;
    if (int'(count_v[sel]) > dep) begin
      n_err++;
      $display("FAIL count_bound: cycle %0d got %0d expected <= %0d", cyc, count_v[sel], dep);
    end
  endtask

  task automatic cycle();
    eval();
    advance();
  endtask

  task automatic do_reset(input int s);
    sel        = s;
    dep        = depth_of(s);
    core_q.delete();
    exp_q.delete();
    hold_valid = 1'b0;
    rst        = 1'b1;
    flush      = 1'b0;
    pop_ready  = 1'b0;
    repeat (2) cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(0);
    for (int k = 0; k < NI; k++) begin
      n_vec++;
      if (count_v[k] !== 3'd0) begin
        n_err++;
        $display("FAIL reset_count: inst %0d got %0d expected 0", k, count_v[k]);
      end
    end
    eval();
    n_vec++;
    if (pop_valid_v[sel] !== 1'b0) begin
      n_err++;
      $display("FAIL reset_pop_valid: got %0b expected 0", pop_valid_v[sel]);
    end
    advance();
    push_core(8'd7, 16'h1234);
    eval();
    n_vec++;
    if (pop_valid_v[sel] !== 1'b1) begin
      n_err++;
      $display("FAIL reset_then_valid: got %0b expected 1", pop_valid_v[sel]);
    end
    advance();
  endtask

  task automatic test_bypass();
    do_reset(0);
    push_core(8'd3, 16'hb003);
    push_core(8'd5, 16'ha005);
    pop_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      eval();
      n_vec++;
      if (pop_pri_v[sel] !== ((i == 0) ? 8'd5 : 8'd3) || qpv_v[sel] !== 1'b1) begin
        n_err++;
        $display("FAIL bypass_pri: beat %0d got %0d/%0b expected %0d/1", i, pop_pri_v[sel], qpv_v[sel], (i == 0) ? 5 : 3);
      end
      advance();
      n_vec++;
      if (count_v[sel] !== 3'd0) begin
        n_err++;
        $display("FAIL bypass_count: beat %0d got %0d expected 0", i, count_v[sel]);
      end
    end
    cycle();
    pop_ready = 1'b0;
  endtask

  task automatic test_fill_stall();
    logic [W-1:0] first;
    do_reset(1);
    for (int i = 0; i < 6; i++) push_core(PW'(60 - 10 * i), DW'($urandom));
    first     = core_q[0];
    pop_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      eval();
      n_vec++;
      if (qpv_v[sel] !== 1'b1) begin
        n_err++;
        $display("FAIL fill_qpv: beat %0d got %0b expected 1", i, qpv_v[sel]);
      end
      advance();
    end
    eval();
    n_vec++;
    if (qpv_v[sel] !== 1'b0 || count_v[sel] !== 3'd4 || {pop_pri_v[sel], pop_data_v[sel]} !== first) begin
      n_err++;
      $display("FAIL fill_full: got qpv=%0b count=%0d head=%h expected 0/4/%h", qpv_v[sel], count_v[sel], {pop_pri_v[sel], pop_data_v[sel]}, first);
    end
    advance();
  endtask

  task automatic test_drain();
    int exp_cnt[6] = '{4, 4, 3, 2, 1, 0};
    pop_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      n_vec++;
      if (count_v[sel] !== 3'(exp_cnt[i])) begin
        n_err++;
        $display("FAIL drain_count: beat %0d got %0d expected %0d", i, count_v[sel], exp_cnt[i]);
      end
    end
    eval();
    n_vec++;
    if (pop_valid_v[sel] !== 1'b0) begin
      n_err++;
      $display("FAIL drain_empty: got %0b expected 0", pop_valid_v[sel]);
    end
    advance();
    pop_ready = 1'b0;
  endtask

  task automatic test_flush();
    logic [W-1:0] head;
    do_reset(1);
    for (int i = 0; i < 5; i++) push_core(PW'(90 - 10 * i), DW'($urandom));
    pop_ready = 1'b0;
    repeat (3) cycle();
    n_vec++;
    if (count_v[sel] !== 3'd3) begin
      n_err++;
      $display("FAIL flush_pre_count: got %0d expected 3", count_v[sel]);
    end
    head      = core_q[0];
    flush     = 1'b1;
    pop_ready = 1'b1;
    eval();
    n_vec++;
    if (pop_valid_v[sel] !== 1'b0 || qpv_v[sel] !== 1'b0) begin
      n_err++;
      $display("FAIL flush_outputs: got pv=%0b qpv=%0b expected 0/0", pop_valid_v[sel], qpv_v[sel]);
    end
    advance();
    flush     = 1'b0;
    pop_ready = 1'b0;
    n_vec++;
    if (count_v[sel] !== 3'd0) begin
      n_err++;
      $display("FAIL flush_count: got %0d expected 0", count_v[sel]);
    end
    eval();
    n_vec++;
    if (pop_valid_v[sel] !== 1'b1 || {pop_pri_v[sel], pop_data_v[sel]} !== head) begin
      n_err++;
      $display("FAIL flush_next_head: got %0b/%h expected 1/%h", pop_valid_v[sel], {pop_pri_v[sel], pop_data_v[sel]}, head);
    end
    advance();
  endtask

  task automatic test_depth1_random();
    do_reset(2);
    for (int i = 0; i < 10000; i++) begin
      pop_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) push_random();
      cycle();
    end
    pop_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset(3);
    for (int i = 0; i < 4; i++) push_random();
    pop_ready = 1'b0;
    repeat (2) cycle();
    n_vec++;
    if (count_v[sel] !== 3'd2) begin
      n_err++;
      $display("FAIL rstmid_pre_count: got %0d expected 2", count_v[sel]);
    end
    rst       = 1'b1;
    pop_ready = 1'b1;
    eval();
    n_vec++;
    if (qpv_v[sel] !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_qpv: got %0b expected 0", qpv_v[sel]);
    end
    advance();
    rst = 1'b0;
    n_vec++;
    if (count_v[sel] !== 3'd0) begin
      n_err++;
      $display("FAIL rstmid_count: got %0d expected 0", count_v[sel]);
    end
    for (int i = 0; i < 100; i++) begin
      pop_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 1) == 0) push_random();
      cycle();
    end
    flush     = 1'b0;
    pop_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_fill_stall();
    test_drain();
    test_flush();
    test_depth1_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
